// File: rtl/sram_port_arbiter_if.sv
// Purpose: requester A/B command/response channels plus the RW0 SRAM macro pins, shared by the arbiter and its environment.
// Latency: none (wires only).
// Backpressure: per-requester valid/ready on commands; responses are not back-pressured.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 88,
    parameter int MASK_W = 4
);
    logic              a_req_valid;
    logic              a_req_ready;
    logic [ADDR_W-1:0] a_req_addr;
    logic              a_req_wmode;
    logic [MASK_W-1:0] a_req_wmask;
    logic [DATA_W-1:0] a_req_wdata;
    logic              a_rsp_valid;
    logic [DATA_W-1:0] a_rsp_rdata;

    logic              b_req_valid;
    logic              b_req_ready;
    logic [ADDR_W-1:0] b_req_addr;
    logic              b_req_wmode;
    logic [MASK_W-1:0] b_req_wmask;
    logic [DATA_W-1:0] b_req_wdata;
    logic              b_rsp_valid;
    logic [DATA_W-1:0] b_rsp_rdata;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    // Arbiter side
    modport slave (
        input  a_req_valid, a_req_addr, a_req_wmode, a_req_wmask, a_req_wdata,
        output a_req_ready, a_rsp_valid, a_rsp_rdata,
        input  b_req_valid, b_req_addr, b_req_wmode, b_req_wmask, b_req_wdata,
        output b_req_ready, b_rsp_valid, b_rsp_rdata,
        output sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata,
        input  sram_rdata
    );

    // Requester / SRAM side
    modport master (
        output a_req_valid, a_req_addr, a_req_wmode, a_req_wmask, a_req_wdata,
        input  a_req_ready, a_rsp_valid, a_rsp_rdata,
        output b_req_valid, b_req_addr, b_req_wmode, b_req_wmask, b_req_wdata,
        input  b_req_ready, b_rsp_valid, b_rsp_rdata,
        input  sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose: clears a single-port SRAM after reset, then round-robins it between requesters A and B.
// Latency: grant is combinational; read data returns on the winner's rsp one cycle after the grant.
// Backpressure: ready only for the granted side (never during the clear sweep); responses cannot be stalled.
module sram_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 88,
    parameter int MASK_W = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sram_port_arbiter_if.slave    bus,
    output logic                  init_done
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_ptr, init_ptr_nxt;
    logic              rr_ptr, rr_ptr_nxt;       // 0 = A preferred, 1 = B preferred
    logic              a_rsp_valid, b_rsp_valid;
    logic              grant_a, grant_b;

    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_INIT;
            init_ptr    <= '0;
            rr_ptr      <= 1'b0;
            init_done   <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_ptr    <= init_ptr_nxt;
            rr_ptr      <= rr_ptr_nxt;
            init_done   <= (state_nxt == S_RUN);
            a_rsp_valid <= grant_a && !bus.a_req_wmode;
            b_rsp_valid <= grant_b && !bus.b_req_wmode;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        rr_ptr_nxt   = rr_ptr;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        sram_en      = 1'b0;
        sram_wmode   = 1'b0;
        sram_addr    = '0;
        sram_wmask   = '0;
        sram_wdata   = '0;
        case (state)
            S_INIT: begin
                sram_en      = 1'b1;
                sram_wmode   = 1'b1;
                sram_wmask   = '1;
                sram_addr    = init_ptr;
                init_ptr_nxt = init_ptr + 1'b1;
                if (init_ptr == LAST_ADDR) begin
                    state_nxt    = S_RUN;
                    init_ptr_nxt = '0;
                end
            end
            S_RUN: begin
                grant_a = bus.a_req_valid && (!bus.b_req_valid || !rr_ptr);
                grant_b = bus.b_req_valid && (!bus.a_req_valid ||  rr_ptr);
                if (grant_a) begin
                    rr_ptr_nxt = 1'b1;
                    sram_en    = 1'b1;
                    sram_wmode = bus.a_req_wmode;
                    sram_addr  = bus.a_req_addr;
                    sram_wmask = bus.a_req_wmask;
                    sram_wdata = bus.a_req_wdata;
                end else if (grant_b) begin
                    rr_ptr_nxt = 1'b0;
                    sram_en    = 1'b1;
                    sram_wmode = bus.b_req_wmode;
                    sram_addr  = bus.b_req_addr;
                    sram_wmask = bus.b_req_wmask;
                    sram_wdata = bus.b_req_wdata;
                end
            end
            default: state_nxt = S_INIT;
        endcase
        // Keep the macro idle and requesters stalled while reset is held.
        if (!reset_n) begin
            sram_en = 1'b0;
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    assign bus.a_req_ready = grant_a;
    assign bus.b_req_ready = grant_b;
    assign bus.a_rsp_valid = a_rsp_valid;
    assign bus.b_rsp_valid = b_rsp_valid;
    assign bus.a_rsp_rdata = bus.sram_rdata;
    assign bus.b_rsp_rdata = bus.sram_rdata;
    assign bus.sram_en     = sram_en;
    assign bus.sram_wmode  = sram_wmode;
    assign bus.sram_addr   = sram_addr;
    assign bus.sram_wmask  = sram_wmask;
    assign bus.sram_wdata  = sram_wdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural RW0 SRAM model preloaded with nonzero junk.
module tb_sram_port_arbiter;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int DATA_W = 88;
    localparam int MASK_W = 4;
    localparam int LANE_W = DATA_W / MASK_W;

    localparam logic [DATA_W-1:0] JUNK = {22{4'h5}};
    localparam logic [DATA_W-1:0] PAT  = {22{4'hA}};
    localparam logic [DATA_W-1:0] EXP9 = PAT & {22'h0, 22'h3FFFFF, 22'h0, 22'h3FFFFF};

    logic clock = 1'b0;
    logic reset_n;
    logic init_done;
    logic fill;
    int   checks = 0;
    int   failures = 0;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    assign bus.sram_rdata = rdata_q;

    always @(posedge clock) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= JUNK;
            rdata_q <= JUNK;
        end else if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                for (int l = 0; l < MASK_W; l++)
                    if (bus.sram_wmask[l])
                        mem[bus.sram_addr][l*LANE_W +: LANE_W] <= bus.sram_wdata[l*LANE_W +: LANE_W];
            end else begin
                rdata_q <= mem[bus.sram_addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_req_valid = 1'b0; bus.a_req_addr = '0; bus.a_req_wmode = 1'b0;
        bus.a_req_wmask = '0;   bus.a_req_wdata = '0;
        bus.b_req_valid = 1'b0; bus.b_req_addr = '0; bus.b_req_wmode = 1'b0;
        bus.b_req_wmask = '0;   bus.b_req_wdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fill    = 1'b1;
        idle_inputs();
        tick();
        fill = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.sram_en, bus.a_req_ready, bus.b_req_ready, bus.a_rsp_valid, bus.b_rsp_valid, init_done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got en/ardy/brdy/arsp/brsp/done=%b expected 000000",
                     {bus.sram_en, bus.a_req_ready, bus.b_req_ready, bus.a_rsp_valid, bus.b_rsp_valid, init_done});
        end
    endtask

    // Entered at posedge+1 of the first sweep cycle; leaves at negedge of cycle n when the sweep is complete.
    task automatic test_init_sweep(input int n);
        logic [ADDR_W+DATA_W+MASK_W+4:0] got, exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            got = {bus.sram_en, bus.sram_wmode, bus.sram_wmask, bus.sram_wdata, bus.sram_addr,
                   bus.a_req_ready, bus.b_req_ready, init_done};
            exp = {1'b1, 1'b1, 4'hF, 88'h0, 6'(i), 1'b0, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL init_sweep cycle %0d got addr=%0d en=%b wmode=%b wmask=%h ardy=%b brdy=%b done=%b wdata=%h expected addr=%0d en=1 wmode=1 wmask=f rdy=0 done=0 wdata=0",
                         i, bus.sram_addr, bus.sram_en, bus.sram_wmode, bus.sram_wmask,
                         bus.a_req_ready, bus.b_req_ready, init_done, bus.sram_wdata, i);
            end
            tick();
        end
        if (n == DEPTH) begin
            @(negedge clock);
            checks++;
            if ({init_done, bus.sram_en, bus.a_req_ready, bus.b_req_ready} !== 4'b1000) begin
                failures++;
                $display("FAIL init_done_rise got done/en/ardy/brdy=%b expected 1000",
                         {init_done, bus.sram_en, bus.a_req_ready, bus.b_req_ready});
            end
        end
    endtask

    task automatic test_read_after_init();
        tick();
        bus.a_req_valid = 1'b1; bus.a_req_wmode = 1'b0; bus.a_req_addr = 6'd5;
        bus.a_req_wmask = 4'hF; bus.a_req_wdata = JUNK;
        @(negedge clock);
        checks++;
        if ({bus.a_req_ready, bus.b_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr} !== {4'b1010, 6'd5}) begin
            failures++;
            $display("FAIL read5_grant got ardy=%b brdy=%b en=%b wmode=%b addr=%0d expected 1 0 1 0 5",
                     bus.a_req_ready, bus.b_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr);
        end
        tick();
        bus.a_req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b10 || bus.a_rsp_rdata !== '0) begin
            failures++;
            $display("FAIL read5_rsp got arsp=%b brsp=%b rdata=%h expected 1 0 0",
                     bus.a_rsp_valid, bus.b_rsp_valid, bus.a_rsp_rdata);
        end
        tick();
        @(negedge clock);
        checks++;
        if ({bus.a_rsp_valid, bus.sram_en} !== 2'b00) begin
            failures++;
            $display("FAIL read5_single_pulse got arsp=%b en=%b expected 0 0", bus.a_rsp_valid, bus.sram_en);
        end
    endtask

    task automatic test_masked_write();
        tick();
        bus.b_req_valid = 1'b1; bus.b_req_wmode = 1'b1; bus.b_req_addr = 6'd9;
        bus.b_req_wmask = 4'b0101; bus.b_req_wdata = PAT;
        @(negedge clock);
        checks++;
        if ({bus.b_req_ready, bus.a_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_wmask, bus.sram_addr} !== {4'b1011, 4'b0101, 6'd9}
            || bus.sram_wdata !== PAT) begin
            failures++;
            $display("FAIL b_write_grant got brdy=%b ardy=%b en=%b wmode=%b wmask=%b addr=%0d wdata=%h expected 1 0 1 1 0101 9 %h",
                     bus.b_req_ready, bus.a_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_wmask,
                     bus.sram_addr, bus.sram_wdata, PAT);
        end
        tick();
        bus.b_req_valid = 1'b0;
        bus.a_req_valid = 1'b1; bus.a_req_wmode = 1'b0; bus.a_req_addr = 6'd9;
        @(negedge clock);
        checks++;
        if ({bus.a_req_ready, bus.a_rsp_valid, bus.b_rsp_valid} !== 3'b100) begin
            failures++;
            $display("FAIL write_no_rsp got ardy=%b arsp=%b brsp=%b expected 1 0 0",
                     bus.a_req_ready, bus.a_rsp_valid, bus.b_rsp_valid);
        end
        tick();
        bus.a_req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.a_rsp_valid !== 1'b1 || bus.a_rsp_rdata !== EXP9) begin
            failures++;
            $display("FAIL read9_after_write got arsp=%b rdata=%h expected 1 %h",
                     bus.a_rsp_valid, bus.a_rsp_rdata, EXP9);
        end
    endtask

    task automatic test_b_read();
        tick();
        bus.b_req_valid = 1'b1; bus.b_req_wmode = 1'b0; bus.b_req_addr = 6'd9;
        @(negedge clock);
        checks++;
        if ({bus.b_req_ready, bus.a_req_ready} !== 2'b10) begin
            failures++;
            $display("FAIL b_read_grant got brdy=%b ardy=%b expected 1 0", bus.b_req_ready, bus.a_req_ready);
        end
        tick();
        bus.b_req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.b_rsp_valid, bus.a_rsp_valid} !== 2'b10 || bus.b_rsp_rdata !== EXP9) begin
            failures++;
            $display("FAIL b_read_rsp got brsp=%b arsp=%b rdata=%h expected 1 0 %h",
                     bus.b_rsp_valid, bus.a_rsp_valid, bus.b_rsp_rdata, EXP9);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        logic [1:0] prev_gnt = 2'b00;
        tick();
        bus.a_req_valid = 1'b1; bus.a_req_wmode = 1'b0; bus.a_req_addr = 6'd1;
        bus.b_req_valid = 1'b1; bus.b_req_wmode = 1'b0; bus.b_req_addr = 6'd2;
        for (int c = 0; c < 4; c++) begin
            exp_gnt = (c % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clock);
            checks++;
            if ({bus.a_req_ready, bus.b_req_ready} !== exp_gnt
                || bus.sram_addr !== ((c % 2 == 0) ? 6'd1 : 6'd2)) begin
                failures++;
                $display("FAIL contend_grant cycle %0d got ardy/brdy=%b addr=%0d expected %b addr=%0d",
                         c, {bus.a_req_ready, bus.b_req_ready}, bus.sram_addr, exp_gnt, (c % 2 == 0) ? 1 : 2);
            end
            checks++;
            if ({bus.a_rsp_valid, bus.b_rsp_valid} !== prev_gnt) begin
                failures++;
                $display("FAIL contend_rsp cycle %0d got arsp/brsp=%b expected %b",
                         c, {bus.a_rsp_valid, bus.b_rsp_valid}, prev_gnt);
            end
            prev_gnt = exp_gnt;
            tick();
        end
        bus.a_req_valid = 1'b0;
        bus.b_req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.a_req_ready, bus.b_req_ready} !== 4'b0100) begin
            failures++;
            $display("FAIL contend_last_rsp got arsp/brsp/ardy/brdy=%b expected 0100",
                     {bus.a_rsp_valid, bus.b_rsp_valid, bus.a_req_ready, bus.b_req_ready});
        end
    endtask

    task automatic test_full_rate();
        int rsp_cnt = 0;
        tick();
        bus.a_req_valid = 1'b1; bus.a_req_wmode = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.a_req_addr = 6'(c);
            @(negedge clock);
            if (bus.a_rsp_valid === 1'b1) rsp_cnt++;
            checks++;
            if (bus.a_req_ready !== 1'b1 || bus.a_rsp_valid !== (c > 0)) begin
                failures++;
                $display("FAIL full_rate cycle %0d got ardy=%b arsp=%b expected 1 %b",
                         c, bus.a_req_ready, bus.a_rsp_valid, (c > 0));
            end
            tick();
        end
        bus.a_req_valid = 1'b0;
        @(negedge clock);
        if (bus.a_rsp_valid === 1'b1) rsp_cnt++;
        checks++;
        if (rsp_cnt !== 8) begin
            failures++;
            $display("FAIL full_rate_rsp_count got %0d expected 8", rsp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.a_req_valid = 1'b1; bus.a_req_wmode = 1'b0; bus.a_req_addr = 6'd3;
        @(negedge clock);
        checks++;
        if (bus.a_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_grant got ardy=%b expected 1", bus.a_req_ready);
        end
        #1;
        reset_n = 1'b0;
        bus.a_req_valid = 1'b0;
        #1;
        checks++;
        if ({init_done, bus.sram_en, bus.a_req_ready} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_run got done/en/ardy=%b expected 000", {init_done, bus.sram_en, bus.a_req_ready});
        end
        tick();
        @(negedge clock);
        checks++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL dropped_rsp got arsp/brsp=%b expected 00", {bus.a_rsp_valid, bus.b_rsp_valid});
        end
        tick();
        reset_n = 1'b1;
        test_init_sweep(30);
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({init_done, bus.sram_en, bus.a_req_ready, bus.b_req_ready, bus.a_rsp_valid, bus.b_rsp_valid} !== 6'b0) begin
                failures++;
                $display("FAIL reset_at_init30 cycle %0d got done/en/ardy/brdy/arsp/brsp=%b expected 000000",
                         c, {init_done, bus.sram_en, bus.a_req_ready, bus.b_req_ready, bus.a_rsp_valid, bus.b_rsp_valid});
            end
            tick();
        end
        reset_n = 1'b1;
        test_init_sweep(DEPTH);
    endtask

    initial begin
        test_reset();
        tick();
        reset_n = 1'b1;
        test_init_sweep(DEPTH);
        test_read_after_init();
        test_masked_write();
        test_b_read();
        test_contention();
        test_full_rate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
